// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory handshake plus the decode/control side of fetch_unit.
interface fetch_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] instr;
  logic [4:0]  opcode;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic        instr_ready;
  logic        halt;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;
  logic        err;

  modport master (
    output imem_req, imem_addr, instr, opcode, pc_out, pc_plus2, instr_valid, halted, err,
    input  imem_rdata, imem_valid, instr_ready, halt, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, pc_out, pc_plus2, instr_valid, halted, err,
    output imem_rdata, imem_valid, instr_ready, halt, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request handshake and a one-entry instruction buffer.
// Define FETCH_PERF_EN to add the fetch_count/stall_count performance counters.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     fif
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_HALT} state_t;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  wait_q, wait_d;
  logic        bubble_q, bubble_d;
  logic        err_q, err_d;
  logic        req_int;

  // A bubble is the one idle S_REQ cycle left behind by a redirect that dropped a returning word.
  assign req_int = (state_q == S_REQ) && !bubble_q;

  // NOTE: defaults first so every path assigns every target and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    wait_d   = wait_q;
    bubble_d = bubble_q;
    err_d    = err_q;

    if (fif.imem_valid && !req_int) err_d = 1'b1;

    if (state_q != S_HALT) begin
      if (fif.redirect) begin
        pc_d     = {fif.redirect_pc[15:1], 1'b0};
        bubble_d = req_int && fif.imem_valid;
        wait_d   = '0;
        state_d  = S_REQ;
        if (fif.redirect_pc[0]) err_d = 1'b1;
      end else if (state_q == S_HOLD) begin
        if (fif.instr_ready) begin
          if (fif.halt) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + 16'd2;
            state_d = S_REQ;
          end
        end
      end else if (bubble_q) begin
        bubble_d = 1'b0;
      end else if (fif.imem_valid) begin
        instr_d  = fif.imem_rdata;
        pc_out_d = pc_q;
        wait_d   = '0;
        state_d  = S_HOLD;
      end else if (wait_q < MAX_W) begin
        // Saturating wait counter; fetch keeps waiting once the timeout error is flagged.
        wait_d = wait_q + 8'd1;
        if (wait_d == MAX_W) err_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      instr_q  <= '0;
      wait_q   <= '0;
      bubble_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      wait_q   <= wait_d;
      bubble_q <= bubble_d;
      err_q    <= err_d;
    end
  end

  // Every output reads as zero while rst is asserted, whatever the registers hold.
  assign fif.imem_req    = req_int && !rst;
  assign fif.imem_addr   = rst ? 16'h0000 : pc_q;
  assign fif.instr       = rst ? 16'h0000 : instr_q;
  assign fif.opcode      = fif.instr[15:11];
  assign fif.pc_out      = rst ? 16'h0000 : pc_out_q;
  assign fif.pc_plus2    = rst ? 16'h0000 : pc_out_q + 16'd2;
  assign fif.instr_valid = (state_q == S_HOLD) && !rst;
  assign fif.halted      = (state_q == S_HALT) && !rst;
  assign fif.err         = err_q && !rst;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        fetch_inc, stall_inc;

  assign fetch_inc = (state_q == S_HOLD) && fif.instr_ready && !fif.redirect;
  assign stall_inc = (req_int && !fif.imem_valid) || ((state_q == S_HOLD) && !fif.instr_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_inc) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_inc) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = rst ? 32'd0 : fetch_cnt_q;
  assign stall_count = rst ? 32'd0 : stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model, plus a directed
// wrap/timeout run on a second instance with RESET_PC=16'hFFFE.
module tb_fetch_unit;
  localparam int MAXW = 15;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_if f0 ();
  fetch_if f1 ();

`ifdef FETCH_PERF_EN
  logic [31:0] fc0, sc0, fc1, sc1;
`endif

  fetch_unit #(.RESET_PC(16'h0000), .MAX_WAIT(MAXW)) dut0 (
    .clk(clk), .rst(rst0), .fif(f0)
`ifdef FETCH_PERF_EN
    , .fetch_count(fc0), .stall_count(sc0)
`endif
  );

  fetch_unit #(.RESET_PC(16'hFFFE), .MAX_WAIT(MAXW)) dut1 (
    .clk(clk), .rst(rst1), .fif(f1)
`ifdef FETCH_PERF_EN
    , .fetch_count(fc1), .stall_count(sc1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: which instruction address is outstanding, whether one is buffered, halt/err flags.
  bit [15:0] m_pc, m_instr, m_ipc;
  bit        m_have, m_halted, m_err, m_bubble;
  int        m_silent;
  int        lat = -1;

  function automatic bit exp_req();
    return !m_have && !m_halted && !m_bubble;
  endfunction

  task automatic compare_outputs();
    bit [15:0] e_plus2;
    if (rst0) begin
      check("rst_req", f0.imem_req, 0);
      check("rst_ivalid", f0.instr_valid, 0);
      check("rst_halted", f0.halted, 0);
      check("rst_err", f0.err, 0);
    end else begin
      check("req", f0.imem_req, exp_req());
      if (exp_req()) check("addr", f0.imem_addr, m_pc);
      check("ivalid", f0.instr_valid, m_have);
      if (m_have) begin
        e_plus2 = m_ipc + 16'd2;
        check("instr", f0.instr, m_instr);
        check("opcode", f0.opcode, m_instr[15:11]);
        check("pc_out", f0.pc_out, m_ipc);
        check("pc_plus2", f0.pc_plus2, e_plus2);
      end
      check("halted", f0.halted, m_halted);
      check("err", f0.err, m_err);
    end
  endtask

  task automatic drive_inputs(input bit do_rst, input int cyc);
    bit [15:0] rp;
    rst0 = do_rst;
    rp = 16'($urandom);
    if ($urandom_range(0, 7) != 0) rp[0] = 1'b0;
    f0.redirect    = !do_rst && ($urandom_range(0, 11) == 0);
    f0.redirect_pc = rp;
    f0.instr_ready = ($urandom_range(0, 3) != 0);
    f0.halt        = (cyc > 100) && ($urandom_range(0, 29) == 0);
    f0.imem_rdata  = 16'($urandom);
    if (!do_rst && exp_req()) begin
      if (lat < 0) lat = ($urandom_range(0, 15) == 0) ? 18 : int'($urandom_range(0, 3));
      f0.imem_valid = (lat == 0);
      lat = (lat == 0) ? -1 : lat - 1;
    end else begin
      lat = -1;
      f0.imem_valid = !do_rst && ($urandom_range(0, 299) == 0);
    end
    if (f0.redirect) lat = -1;
  endtask

  task automatic model_step();
    bit req;
    if (rst0) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
      m_have = 0; m_halted = 0; m_err = 0; m_bubble = 0; m_silent = 0;
      return;
    end
    req = exp_req();
    if (f0.imem_valid && !req) m_err = 1;
    if (m_halted) return;
    if (f0.redirect) begin
      if (f0.redirect_pc[0]) m_err = 1;
      m_pc     = f0.redirect_pc & 16'hFFFE;
      m_bubble = req && f0.imem_valid;
      m_have   = 0;
      m_silent = 0;
    end else if (m_have) begin
      if (f0.instr_ready) begin
        m_have = 0;
        if (f0.halt) m_halted = 1;
        else m_pc = m_pc + 16'd2;
      end
    end else if (m_bubble) begin
      m_bubble = 0;
    end else if (f0.imem_valid) begin
      m_have = 1; m_instr = f0.imem_rdata; m_ipc = m_pc; m_silent = 0;
    end else if (m_silent < MAXW) begin
      m_silent++;
      if (m_silent == MAXW) m_err = 1;
    end
  endtask

  task automatic run_cycle(input bit do_rst, input int cyc);
    @(negedge clk);
    compare_outputs();
    drive_inputs(do_rst, cyc);
    model_step();
  endtask

  initial begin
    f0.imem_valid = 0; f0.imem_rdata = '0; f0.instr_ready = 0;
    f0.halt = 0; f0.redirect = 0; f0.redirect_pc = '0;
    f1.imem_valid = 0; f1.imem_rdata = '0; f1.instr_ready = 0;
    f1.halt = 0; f1.redirect = 0; f1.redirect_pc = '0;

    for (int seg = 0; seg < 6; seg++)
      for (int cyc = 0; cyc < 350; cyc++)
        run_cycle(cyc < 2, cyc);

    // Directed: RESET_PC=FFFE wraps to 0000 after one accept, then a silent memory times out.
    @(negedge clk);
    check("d1_rst_req", f1.imem_req, 0);
    rst1 = 1'b0;
    @(negedge clk);
    check("d1_req0", f1.imem_req, 1);
    check("d1_addr0", f1.imem_addr, 16'hFFFE);
    f1.imem_valid = 1'b1;
    f1.imem_rdata = 16'h4000;
    @(negedge clk);
    f1.imem_valid = 1'b0;
    check("d1_ivalid", f1.instr_valid, 1);
    check("d1_opcode", f1.opcode, 5'b01000);
    check("d1_pc_out", f1.pc_out, 16'hFFFE);
    check("d1_pc_plus2", f1.pc_plus2, 16'h0000);
    f1.instr_ready = 1'b1;
    @(negedge clk);
    f1.instr_ready = 1'b0;
    check("d1_req_wrap", f1.imem_req, 1);
    check("d1_addr_wrap", f1.imem_addr, 16'h0000);
    check("d1_err_pre", f1.err, 0);
    for (int i = 1; i <= MAXW; i++) begin
      @(negedge clk);
      check("d1_timeout_err", f1.err, (i == MAXW) ? 1 : 0);
    end
    check("d1_still_waiting", f1.imem_req, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
